// File: rtl/division_block_pkg.sv
// Shared definitions for the division_block integer divide/remainder unit:
// width parameters, operation codes, FSM state codes and sign helpers.
package division_block_pkg;

    localparam int XLEN        = 32;
    localparam int COUNT_WIDTH = $clog2(XLEN);

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] value,
                                                    input logic           negate);
        return negate ? (~value + {{(XLEN-1){1'b0}}, 1'b1}) : value;
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] value);
        return cond_negate(value, value[XLEN-1]);
    endfunction

endpackage

// File: rtl/division_block_if.sv
// Request/result bundle of division_block; master issues requests, slave is the divider.
interface division_block_if;
    import division_block_pkg::*;

    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            data_valid;
    logic [1:0]      operation;
    logic [XLEN-1:0] product_o;
    logic            divided_by_zero;
    logic            data_ready;

    modport master (
        output dividend, divisor, data_valid, operation,
        input  product_o, divided_by_zero, data_ready
    );

    modport slave (
        input  dividend, divisor, data_valid, operation,
        output product_o, divided_by_zero, data_ready
    );

endinterface

// File: rtl/division_block_div_core_unsigned.sv
// Unsigned restoring divider core: one quotient bit per clock for XLEN clocks after start.
module div_core_unsigned
    import division_block_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            done
);

    logic [XLEN-1:0]        rem_r;
    logic [XLEN-1:0]        quo_r;
    logic [XLEN-1:0]        div_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic                   busy_r;

    logic [XLEN:0]          shifted_s;
    logic [XLEN+1:0]        diff_s;
    logic                   fits_s;

    // Trial subtraction; the extra top bit is the borrow that marks a negative result.
    always_comb begin
        shifted_s = {rem_r, quo_r[XLEN-1]};
        diff_s    = {1'b0, shifted_s} - {2'b00, div_r};
        fits_s    = ~diff_s[XLEN+1];
    end

    assign done      = busy_r && (count_r == COUNT_WIDTH'(XLEN-1));
    assign quotient  = quo_r;
    assign remainder = rem_r;

    // Iteration state: load on start, then shift/subtract until the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r   <= {XLEN{1'b0}};
            quo_r   <= {XLEN{1'b0}};
            div_r   <= {XLEN{1'b0}};
            count_r <= {COUNT_WIDTH{1'b0}};
            busy_r  <= 1'b0;
        end else if (start) begin
            rem_r   <= {XLEN{1'b0}};
            quo_r   <= dividend;
            div_r   <= divisor;
            count_r <= {COUNT_WIDTH{1'b0}};
            busy_r  <= 1'b1;
        end else if (busy_r) begin
            rem_r   <= fits_s ? diff_s[XLEN-1:0] : shifted_s[XLEN-1:0];
            quo_r   <= {quo_r[XLEN-2:0], fits_s};
            count_r <= count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            busy_r  <= ~done;
        end
    end

endmodule

// File: rtl/division_block.sv
// RISC-V M-extension DIV/DIVU/REM/REMU unit around an unsigned iterative core.
// Optional `DIV_ZERO_FASTPATH_EN: a zero divisor completes one cycle after accept.
module division_block
    import division_block_pkg::*;
(
    input  logic              CLK,
    input  logic              rst,
    division_block_if.slave   bus
);

    logic [1:0]      state_r;
    logic [1:0]      op_r;
    logic [XLEN-1:0] dividend_r;
    logic            q_neg_r;
    logic            r_neg_r;
    logic            zero_r;
    logic [XLEN-1:0] product_r;
    logic            dbz_r;
    logic            ready_r;

    logic            accept_s;
    logic            signed_in_s;
    logic            zero_in_s;
    logic            fast_zero_s;
    logic            core_start_s;
    logic [XLEN-1:0] core_a_s;
    logic [XLEN-1:0] core_b_s;
    logic [XLEN-1:0] core_quo_s;
    logic [XLEN-1:0] core_rem_s;
    logic            core_done_s;
    logic [XLEN-1:0] result_s;

    // Request decode; a zero divisor keeps the raw dividend so the remainder passes through unchanged.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && bus.data_valid;
        signed_in_s = ~bus.operation[0];
        zero_in_s   = (bus.divisor == {XLEN{1'b0}});
`ifdef DIV_ZERO_FASTPATH_EN
        fast_zero_s = zero_in_s;
`else
        fast_zero_s = 1'b0;
`endif
        core_start_s = accept_s && !fast_zero_s;
        if (signed_in_s && !zero_in_s) begin
            core_a_s = magnitude(bus.dividend);
            core_b_s = magnitude(bus.divisor);
        end else begin
            core_a_s = bus.dividend;
            core_b_s = bus.divisor;
        end
    end

    div_core_unsigned u_core (
        .clk       (CLK),
        .rst       (rst),
        .start     (core_start_s),
        .dividend  (core_a_s),
        .divisor   (core_b_s),
        .quotient  (core_quo_s),
        .remainder (core_rem_s),
        .done      (core_done_s)
    );

    // Final result: fixed zero-divisor values, otherwise sign-corrected quotient or remainder.
    always_comb begin
        if (zero_r) begin
            result_s = op_r[1] ? dividend_r : {XLEN{1'b1}};
        end else begin
            result_s = op_r[1] ? cond_negate(core_rem_s, r_neg_r)
                               : cond_negate(core_quo_s, q_neg_r);
        end
    end

    // Control FSM and output registers; DONE commits the result and raises the ready pulse.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            op_r       <= 2'b00;
            dividend_r <= {XLEN{1'b0}};
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            zero_r     <= 1'b0;
            product_r  <= {XLEN{1'b0}};
            dbz_r      <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    if (accept_s) begin
                        op_r       <= bus.operation;
                        dividend_r <= bus.dividend;
                        zero_r     <= zero_in_s;
                        q_neg_r    <= signed_in_s && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
                        r_neg_r    <= signed_in_s && bus.dividend[XLEN-1];
                        state_r    <= fast_zero_s ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    ready_r <= 1'b0;
                    if (core_done_s) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    product_r <= result_s;
                    dbz_r     <= zero_r;
                    ready_r   <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.product_o       = product_r;
    assign bus.divided_by_zero = dbz_r;
    assign bus.data_ready      = ready_r;

endmodule

// File: tb/tb_division_block.sv
// Directed self-checking bench for division_block (honours DIV_ZERO_FASTPATH_EN for zero-divisor latency).
module tb_division_block;
    import division_block_pkg::*;

    logic CLK = 1'b0;
    logic rst;
    division_block_if bus();

    division_block dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

`ifdef DIV_ZERO_FASTPATH_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and check ready timing, pulse shape, result and flag.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic exp_z,
                          input int exp_lat, input bit hold);
        int  cyc;
        bit  seen;
        bus.operation  = op;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.data_valid = 1'b1;
        @(posedge CLK); #1;
        check({tag, " ready_low_after_accept"}, 32'(bus.data_ready), 32'd0);
        bus.data_valid = hold;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            if (hold) begin
                bus.dividend  = $urandom;
                bus.divisor   = $urandom;
                bus.operation = 2'($urandom_range(3, 0));
                if (cyc >= 29) bus.data_valid = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
            if (bus.data_ready === 1'b1) seen = 1'b1;
        end
        bus.data_valid = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " product"}, bus.product_o, exp);
        check({tag, " div_zero"}, 32'(bus.divided_by_zero), 32'(exp_z));
    endtask

    initial begin
        int pulses;
        rst            = 1'b1;
        bus.dividend   = 32'd0;
        bus.divisor    = 32'd0;
        bus.operation  = 2'b00;
        bus.data_valid = 1'b0;
        #1;
        check("reset product", bus.product_o, 32'd0);
        check("reset dbz", 32'(bus.divided_by_zero), 32'd0);
        check("reset ready", 32'(bus.data_ready), 32'd0);
        @(negedge CLK); @(negedge CLK);
        rst = 1'b0;

        run_op("div -7/3",      OP_DIV,  32'hFFFF_FFF9, 32'd3,          32'hFFFF_FFFE, 1'b0, 33, 1'b0);
        run_op("div 149/-2",    OP_DIV,  32'd149,       32'hFFFF_FFFE, 32'hFFFF_FFB6, 1'b0, 33, 1'b0);
        run_op("div -149/-5",   OP_DIV,  32'hFFFF_FF6B, 32'hFFFF_FFFB, 32'd29,        1'b0, 33, 1'b0);
        run_op("div -2/-5",     OP_DIV,  32'hFFFF_FFFE, 32'hFFFF_FFFB, 32'd0,         1'b0, 33, 1'b0);
        run_op("div -5/32",     OP_DIV,  32'hFFFF_FFFB, 32'd32,         32'd0,         1'b0, 33, 1'b0);
        run_op("rem -7%3",      OP_REM,  32'hFFFF_FFF9, 32'd3,          32'hFFFF_FFFF, 1'b0, 33, 1'b0);
        run_op("rem 149%-2",    OP_REM,  32'd149,       32'hFFFF_FFFE, 32'd1,         1'b0, 33, 1'b0);
        run_op("rem -149%-5",   OP_REM,  32'hFFFF_FF6B, 32'hFFFF_FFFB, 32'hFFFF_FFFC, 1'b0, 33, 1'b0);
        run_op("rem 3%-5",      OP_REM,  32'd3,         32'hFFFF_FFFB, 32'd3,         1'b0, 33, 1'b0);
        run_op("rem -5%32",     OP_REM,  32'hFFFF_FFFB, 32'd32,         32'hFFFF_FFFB, 1'b0, 33, 1'b0);
        run_op("divu 25/3",     OP_DIVU, 32'd25,        32'd3,          32'd8,         1'b0, 33, 1'b0);
        run_op("remu 25%3",     OP_REMU, 32'd25,        32'd3,          32'd1,         1'b0, 33, 1'b0);
        run_op("divu 5/32",     OP_DIVU, 32'd5,         32'd32,         32'd0,         1'b0, 33, 1'b0);
        run_op("remu 5%32",     OP_REMU, 32'd5,         32'd32,         32'd5,         1'b0, 33, 1'b0);
        run_op("divu big/3",    OP_DIVU, 32'hFFFF_FFF9, 32'd3,          32'h5555_5553, 1'b0, 33, 1'b0);

        run_op("remu 5/0",      OP_REMU, 32'd5,         32'd0,          32'd5,         1'b1, ZERO_LAT, 1'b0);
        run_op("div 5/0",       OP_DIV,  32'd5,         32'd0,          32'hFFFF_FFFF, 1'b1, ZERO_LAT, 1'b0);
        run_op("rem -7/0",      OP_REM,  32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 1'b1, ZERO_LAT, 1'b0);
        run_op("rem 149%-2 nz", OP_REM,  32'd149,       32'hFFFF_FFFE, 32'd1,         1'b0, 33, 1'b0);

        run_op("div ovf",       OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33, 1'b0);
        run_op("rem ovf",       OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 33, 1'b0);

        // Operand changes while idle must not start anything.
        bus.operation = OP_DIVU;
        bus.dividend  = 32'd14;
        bus.divisor   = 32'd2;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (bus.data_ready === 1'b1) pulses++;
        end
        check("idle no pulse", 32'(pulses), 32'd0);
        check("idle product held", bus.product_o, 32'd0);

        run_op("divu hold valid", OP_DIVU, 32'd1000, 32'd7, 32'd142, 1'b0, 33, 1'b1);
        check("after hold no extra pulse", 32'(bus.data_ready), 32'd1);
        @(posedge CLK); #1;
        check("after hold ready cleared", 32'(bus.data_ready), 32'd0);

        // Reset in flight: outputs clear at once and the discarded request never reports.
        bus.operation  = OP_DIVU;
        bus.dividend   = 32'd100;
        bus.divisor    = 32'd9;
        bus.data_valid = 1'b1;
        @(posedge CLK); #1;
        bus.data_valid = 1'b0;
        repeat (10) @(posedge CLK);
        #2 rst = 1'b1;
        #1;
        check("midreset product", bus.product_o, 32'd0);
        check("midreset dbz", 32'(bus.divided_by_zero), 32'd0);
        check("midreset ready", 32'(bus.data_ready), 32'd0);
        @(negedge CLK); @(negedge CLK);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (bus.data_ready === 1'b1) pulses++;
        end
        check("midreset no pulse", 32'(pulses), 32'd0);
        run_op("after reset divu 100/9", OP_DIVU, 32'd100, 32'd9, 32'd11, 1'b0, 33, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/division_block.md
# division_block

Iterative XLEN-bit integer divide/remainder unit for the RISC-V M-extension execute stage (DIV, DIVU, REM, REMU). Operands and the operation code are captured on a single-cycle valid strobe. The unit computes one quotient bit per clock with a restoring shift-subtract algorithm. It returns either the quotient or the remainder with a one-cycle ready pulse and a divide-by-zero flag.

## Interface
- XLEN, 32, operand/result width.
- COUNT_WIDTH, $clog2(XLEN), iteration counter width.
- CLK  in  1  clock, rising-edge active.
- rst  in  1  reset, asynchronous, active-high.
- dividend  in  XLEN  rs1 operand; sampled only on accept.
- divisor  in  XLEN  rs2 operand; sampled only on accept.
- data_valid  in  1  start strobe.
- operation  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled on accept.
- product_o  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).
- divided_by_zero  out  1  divisor was zero for the reported result.
- data_ready  out  1  one-cycle result-valid pulse.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE:** data_valid=1 at a rising edge accepts the request and latches the operands and operation.
- **Signed ops (DIV, REM):** latch the magnitudes of both operands. Record the quotient sign as sign(dividend) XOR sign(divisor), and the remainder sign as sign(dividend).
- **Unsigned ops (DIVU, REMU):** latch the operands as-is.
- **BUSY:** runs XLEN iterations of the unsigned restoring step.
  - Shift the {remainder, quotient} pair left.
  - Trial-subtract the divisor using an XLEN+1-bit subtractor.
  - If the result is non-negative, keep it and set the quotient LSB.
- **Completion:** apply the sign correction (two's-complement negate where the recorded sign is 1), select quotient or remainder by operation[1], register into product_o and enter DONE.
- **Divisor = 0:** quotient = all ones and remainder = dividend, unmodified, for both signed and unsigned ops; divided_by_zero=1.
- **Signed overflow:** -2^XLEN-1 / -1 gives quotient 0x80000000 and remainder 0, with no flag. This falls out of the magnitude path.
- **Truncation:** the quotient truncates toward zero; the remainder takes the sign of the dividend.
- **DONE:** data_ready=1 for exactly one cycle, then return to IDLE.
- data_valid during BUSY or DONE is ignored.
- Operand changes without data_valid have no effect.
- product_o and divided_by_zero hold their last values until the next completion.

## Timing
- **Reset:** all outputs (product_o, divided_by_zero, data_ready) go to 0 immediately. The state returns to IDLE; any in-flight operation is discarded and produces no ready pulse.
- **Latency:** accept at edge N; iterations on edges N+1..N+XLEN.
- **Result:** product_o, divided_by_zero and data_ready are registered at edge N+XLEN+1. data_ready is high for the following cycle and low after edge N+XLEN+2.
- **Next request:** may be accepted at edge N+XLEN+2, the edge that clears data_ready, so the minimum spacing between requests is XLEN+2 cycles.

## Configuration
- DIV_ZERO_FASTPATH_EN
  - **Defined:** a zero divisor is detected at accept. The result is registered at edge N+1, with data_ready high for one cycle after it.
  - **Undefined:** a zero divisor runs the full XLEN iterations with sign correction suppressed. It gives the identical result and flag at the normal latency.

## Structure
- **Shared package:** operation encodings (DIV/DIVU/REM/REMU) and the state enum (IDLE/BUSY/DONE).
- **Sub-module div_core_unsigned:**
  - Contains the iteration counter, remainder/quotient registers and trial subtractor.
  - Start/done interface.
- **Top level:** sign handling, the zero-divisor path, result select and output registers.

## Test plan
- **DIV:** -7/3 -> 0xFFFFFFFE; 149/-2 -> 0xFFFFFFB6; -149/-5 -> 29; -2/-5 -> 0; -5/32 -> 0. data_ready pulses once per request, at N+33.
- **REM:** -7%3 -> 0xFFFFFFFF; 149%-2 -> 1; -149%-5 -> 0xFFFFFFFC; 3%-5 -> 3; -5%32 -> 0xFFFFFFFB.
- **DIVU/REMU:** 25/3 -> 8, remainder 1; 5/32 -> 0, remainder 5; 0xFFFFFFF9 DIVU 3 -> 0x55555553.
- **Divide by zero:**
  - REMU 5/0 -> 5, and DIV 5/0 -> 0xFFFFFFFF, each with divided_by_zero=1.
  - A following REM 149/-2 -> 1 with divided_by_zero=0.
  - Latency is 1 or 33 cycles per DIV_ZERO_FASTPATH_EN.
- **Control:**
  - Changing the operands to 14/2 while idle without data_valid leaves product_o unchanged and gives no pulse.
  - data_valid held high or re-pulsed while BUSY is ignored.
  - Overflow: DIV 0x80000000 / -1 -> 0x80000000, REM -> 0.
- **Reset mid-operation:** assert rst 10 cycles after accept. All outputs go to 0 immediately and no ready pulse occurs. A new request afterwards completes correctly.
